// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared constants, BCD digit type and 5x5 glyph table for the score renderer
package score_pkg;

  localparam int GLYPH_W   = 5;
  localparam int GLYPH_H   = 5;
  localparam int CELL_BITS = 3;

  typedef logic [3:0] bcd_t;

  // Rows top to bottom, 5 bits per row, bit 4 of each row is the leftmost pixel.
  localparam logic [24:0] GLYPH_TABLE [10] = '{
    25'b11111_10001_10001_10001_11111,  // 0
    25'b01100_00100_00100_00100_11111,  // 1
    25'b11111_00001_11111_10000_11111,  // 2
    25'b11111_00001_11111_00001_11111,  // 3
    25'b10001_10001_11111_00001_00001,  // 4
    25'b11111_10000_11111_00001_11111,  // 5
    25'b11111_10000_11111_10001_11111,  // 6
    25'b11111_00001_00001_00001_00001,  // 7
    25'b11111_10001_11111_10001_11111,  // 8
    25'b11111_10001_11111_00001_11111   // 9
  };

endpackage

// File: rtl/glyph_rom5x5.sv
// rtl/glyph_rom5x5.sv - combinational 5x5 glyph row lookup, blank for codes above 9 or rows above 4
module glyph_rom5x5
  import score_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] row,
  output logic [4:0] row_bits
);

  logic [24:0] word;

  // Select the glyph word and slice out the requested row.
  always_comb begin
    word     = '0;
    row_bits = '0;
    if (digit <= 4'd9) begin
      word = GLYPH_TABLE[digit];
    end
    case (row)
      3'd0:    row_bits = word[24:20];
      3'd1:    row_bits = word[19:15];
      3'd2:    row_bits = word[14:10];
      3'd3:    row_bits = word[9:5];
      3'd4:    row_bits = word[4:0];
      default: row_bits = '0;
    endcase
  end

endmodule

// File: rtl/bcd_score_renderer.sv
// rtl/bcd_score_renderer.sv - BCD score counter with frame-latched, scaled 5x5 glyph rendering (option: SCORE_LEADING_ZERO_BLANK_EN)
module bcd_score_renderer
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int X0         = 64,
  parameter int Y0         = 16,
  parameter int SCALE_LOG2 = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             hpos,
  input  logic [15:0]             vpos,
  input  logic                    inc,
  input  logic [3:0]              inc_amt,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic                    overflow,
  output logic                    pixel
);

  localparam int          CELL = 8 << SCALE_LOG2;
  localparam logic [15:0] X_LO = 16'(X0);
  localparam logic [15:0] X_HI = 16'(X0 + NUM_DIGITS * CELL);
  localparam logic [15:0] Y_LO = 16'(Y0);
  localparam logic [15:0] Y_HI = 16'(Y0 + CELL);

  logic [4*NUM_DIGITS-1:0] sum_next;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    carry_out;
  logic [3:0]              amt;
  logic [4:0]              dsum;
  logic                    carry;
  logic                    frame_latch;

  assign frame_latch = (hpos == 16'd0) && (vpos == 16'd0);

  // Ripple decimal add of the clamped increment across all digits.
  always_comb begin
    amt      = (inc_amt > 4'd9) ? 4'd9 : inc_amt;
    sum_next = '0;
    dsum     = '0;
    carry    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dsum = {1'b0, score_bcd[4*i +: 4]} + {4'b0, carry} + ((i == 0) ? {1'b0, amt} : 5'd0);
      if (dsum >= 5'd10) begin
        dsum  = dsum - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum_next[4*i +: 4] = dsum[3:0];
    end
    carry_out = carry;
  end

  // Live score and sticky overflow; clear beats a simultaneous add.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else if (inc) begin
      score_bcd <= sum_next;
      if (carry_out) overflow <= 1'b1;
    end
  end

  // Display copy taken only at the frame origin so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset)            shadow <= '0;
    else if (frame_latch) shadow <= score_bcd;
  end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_next;
  logic [NUM_DIGITS-1:0] blank;
  logic                  nonzero_seen;

  // A digit is blank while every digit above and including it is zero; digit 0 never blanks.
  always_comb begin
    blank_next   = '0;
    nonzero_seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (score_bcd[4*i +: 4] != 4'd0) nonzero_seen = 1'b1;
      blank_next[i] = !nonzero_seen;
    end
  end

  // Blank mask travels with the shadow so both describe the same frame.
  always_ff @(posedge clk) begin
    if (reset)            blank <= '0;
    else if (frame_latch) blank <= blank_next;
  end
`else
  logic [NUM_DIGITS-1:0] blank;
  assign blank = '0;
`endif

  logic [5:0] rx;
  logic [2:0] ry;
  logic       in_region;

  assign rx        = 6'((hpos - X_LO) >> SCALE_LOG2);
  assign ry        = 3'((vpos - Y_LO) >> SCALE_LOG2);
  assign in_region = (hpos >= X_LO) && (hpos < X_HI) && (vpos >= Y_LO) && (vpos < Y_HI);

  logic       s1_in_region;
  logic [2:0] s1_cell;
  logic [2:0] s1_xofs;
  logic [2:0] s1_yofs;

  // Stage 1: register region membership and cell-relative coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_in_region <= 1'b0;
      s1_cell      <= '0;
      s1_xofs      <= '0;
      s1_yofs      <= '0;
    end else begin
      s1_in_region <= in_region;
      s1_cell      <= rx[CELL_BITS +: 3];
      s1_xofs      <= rx[CELL_BITS-1:0];
      s1_yofs      <= ry;
    end
  end

  bcd_t       digit_sel;
  logic       blank_sel;
  logic [4:0] row_bits;
  logic [4:0] row_shift;

  // Cell 0 is leftmost and therefore shows the most significant digit.
  always_comb begin
    digit_sel = '0;
    blank_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s1_cell == 3'(NUM_DIGITS - 1 - i)) begin
        digit_sel = shadow[4*i +: 4];
        blank_sel = blank[i];
      end
    end
  end

  glyph_rom5x5 u_rom (
    .digit    (digit_sel),
    .row      (s1_yofs),
    .row_bits (row_bits)
  );

  // Shifting left by xofs brings column xofs into bit 4; columns 5..7 shift out to zero.
  assign row_shift = row_bits << s1_xofs;

  // Stage 2: final pixel decision.
  always_ff @(posedge clk) begin
    if (reset) pixel <= 1'b0;
    else       pixel <= s1_in_region && !blank_sel && (s1_xofs < 3'(GLYPH_W))
                        && (s1_yofs < 3'(GLYPH_H)) && row_shift[4];
  end

endmodule
